pwr_gated_alu_seq: RTL and testbench

PWR_GATED_ALU_SEQ -- requirements
Module: pwr_gated_alu_seq

---
 rtl/pwr_gated_alu_seq.sv | 190 +++++++++++++++++++
 tb/tb_pwr_gated_alu_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwr_gated_alu_seq.sv
// Power-gated ALU with an OFF/PWR_UP/ON/DRAIN/ISO sequencer, output isolation clamp
// and a multi-cycle multiply. Nothing in the ALU domain survives a trip through OFF.
//
//   state  | meaning
//   OFF    | switch open, outputs clamped, waiting for pwr_up_req
//   PWR_UP | switch closed, still clamped while the rail settles (PWR_DLY cycles)
//   ON     | powered and unclamped, ops accepted
//   DRAIN  | power-down requested, letting the in-flight op finish
//   ISO    | clamped, still powered for ISO_DLY cycles before the switch opens
module pwr_gated_alu_seq #(
    parameter int          WIDTH     = 16,
    parameter int unsigned CLAMP_VAL = 1,
    parameter int          ISO_DLY   = 2,
    parameter int          PWR_DLY   = 4,
    parameter int          MUL_LAT   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    input  logic             start,
    input  logic             pwr_down_req,
    input  logic             pwr_up_req,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             pwr_en,
    output logic             iso_active,
    output logic [2:0]       pwr_state,
    output logic             start_drop
);

    localparam logic [2:0] S_OFF   = 3'd0;
    localparam logic [2:0] S_PWRUP = 3'd1;
    localparam logic [2:0] S_ON    = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_ISO   = 3'd4;

    localparam logic [3:0] OP_MUL  = 4'd7;

    logic [2:0]       state_q, state_d;
    logic [3:0]       seq_cnt_q, seq_cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             drop_q, drop_d;
    logic [3:0]       mul_cnt_q, mul_cnt_d;
    logic [WIDTH-1:0] mul_a_q, mul_a_d;
    logic [WIDTH-1:0] mul_b_q, mul_b_d;

    logic             accept;
    logic [WIDTH-1:0] alu_val;
    logic [4:0]       shamt;

    assign accept = start && (state_q == S_ON) && !busy_q;
    assign shamt  = B[4:0];

    always_comb begin
        alu_val = '0;
        case (opcode)
            4'd0: alu_val = A + B;
            4'd1: alu_val = A - B;
            4'd2: alu_val = A & B;
            4'd3: alu_val = A | B;
            4'd4: alu_val = A ^ B;
            4'd5: alu_val = (int'(shamt) >= WIDTH) ? '0 : (A << shamt);
            4'd6: alu_val = (int'(shamt) >= WIDTH) ? '0 : (A >> shamt);
            default: alu_val = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        seq_cnt_d = seq_cnt_q;
        res_d     = res_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        drop_d    = 1'b0;
        mul_cnt_d = mul_cnt_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;

        if (start && !accept) begin
            drop_d = 1'b1;
        end

        if (accept) begin
            if (opcode == OP_MUL) begin
                busy_d    = 1'b1;
                mul_cnt_d = 4'(MUL_LAT - 1);
                mul_a_d   = A;
                mul_b_d   = B;
            end else begin
                res_d  = alu_val;
                done_d = 1'b1;
            end
        end else if (busy_q) begin
            if (mul_cnt_q == 4'd0) begin
                res_d  = mul_a_q * mul_b_q;
                done_d = 1'b1;
                busy_d = 1'b0;
            end else begin
                mul_cnt_d = mul_cnt_q - 4'd1;
            end
        end

        case (state_q)
            S_OFF: begin
                if (pwr_up_req) begin
                    state_d   = S_PWRUP;
                    seq_cnt_d = 4'(PWR_DLY - 1);
                end
            end
            S_PWRUP: begin
                if (seq_cnt_q == 4'd0) begin
                    state_d = S_ON;
                end else begin
                    seq_cnt_d = seq_cnt_q - 4'd1;
                end
            end
            S_ON: begin
                // An op accepted in the same cycle as the request must drain too.
                if (pwr_down_req) begin
                    if (busy_q || accept) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d   = S_ISO;
                        seq_cnt_d = 4'(ISO_DLY - 1);
                    end
                end
            end
            S_DRAIN: begin
                if (done_q) begin
                    state_d   = S_ISO;
                    seq_cnt_d = 4'(ISO_DLY - 1);
                end
            end
            S_ISO: begin
                if (seq_cnt_q == 4'd0) begin
                    state_d   = S_OFF;
                    res_d     = '0;
                    busy_d    = 1'b0;
                    mul_cnt_d = '0;
                    mul_a_d   = '0;
                    mul_b_d   = '0;
                end else begin
                    seq_cnt_d = seq_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d   = S_OFF;
                seq_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_OFF;
            seq_cnt_q <= '0;
            res_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
            mul_cnt_q <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            seq_cnt_q <= seq_cnt_d;
            res_q     <= res_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            drop_q    <= drop_d;
            mul_cnt_q <= mul_cnt_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
        end
    end

    assign pwr_en     = (state_q != S_OFF);
    assign iso_active = (state_q == S_OFF) || (state_q == S_PWRUP) || (state_q == S_ISO);
    assign result     = iso_active ? WIDTH'(CLAMP_VAL) : res_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign start_drop = drop_q;
    assign pwr_state  = state_q;

endmodule

// File: tb/tb_pwr_gated_alu_seq.sv
// Bench for pwr_gated_alu_seq: scoreboard of expected results popped on done,
// plus direct checks of the power sequencer timing and start_drop behaviour.
module tb_pwr_gated_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [3:0]   opcode = '0;
    logic         start = 1'b0;
    logic         pwr_down_req = 1'b0;
    logic         pwr_up_req = 1'b0;
    logic [W-1:0] result;
    logic         busy;
    logic         done;
    logic         pwr_en;
    logic         iso_active;
    logic [2:0]   pwr_state;
    logic         start_drop;

    int n_chk = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    pwr_gated_alu_seq dut (
        .clk          (clk),
        .rst          (rst),
        .A            (A),
        .B            (B),
        .opcode       (opcode),
        .start        (start),
        .pwr_down_req (pwr_down_req),
        .pwr_up_req   (pwr_up_req),
        .result       (result),
        .busy         (busy),
        .done         (done),
        .pwr_en       (pwr_en),
        .iso_active   (iso_active),
        .pwr_state    (pwr_state),
        .start_drop   (start_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [31:0] p;
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return (sh >= W) ? '0 : W'(a << sh);
            4'd6: return (sh >= W) ? '0 : W'(a >> sh);
            4'd7: begin
                p = 32'(a) * 32'(b);
                return p[W-1:0];
            end
            default: return '0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) check("sb_unexpected_done", 32'(done), 32'd0);
            else check("sb_result", 32'(result), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic pd);
        A = a; B = b; opcode = op; start = 1'b1; pwr_down_req = pd;
        exp_q.push_back(model(op, a, b));
        tick();
        start = 1'b0; pwr_down_req = 1'b0;
    endtask

    task automatic power_up();
        pwr_up_req = 1'b1;
        tick();
        pwr_up_req = 1'b0;
        check("pu_state", 32'(pwr_state), 32'd1);
        check("pu_pwr_en", 32'(pwr_en), 32'd1);
        repeat (3) tick();
        check("pu_still_pwrup", 32'(pwr_state), 32'd1);
        tick();
        check("pu_on", 32'(pwr_state), 32'd2);
        check("pu_result_zero", 32'(result), 32'd0);
    endtask

    logic [3:0]   t_op[10] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd6, 4'd6, 4'd9, 4'd15, 4'd0};
    logic [W-1:0] t_a[10]  = '{16'hF0F0, 16'h0F00, 16'hAAAA, 16'h0001, 16'h1234,
                               16'h8000, 16'hFFFF, 16'h5555, 16'h1111, 16'h7FFF};
    logic [W-1:0] t_b[10]  = '{16'hFF00, 16'h00F0, 16'hFFFF, 16'h000F, 16'h0010,
                               16'h0003, 16'h0014, 16'h1234, 16'h2222, 16'h0001};

    initial begin
        repeat (2) tick();
        check("rst_state", 32'(pwr_state), 32'd0);
        check("rst_pwr_en", 32'(pwr_en), 32'd0);
        check("rst_iso", 32'(iso_active), 32'd1);
        check("rst_result", 32'(result), 32'h0001);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_drop", 32'(start_drop), 32'd0);
        rst = 1'b0;
        tick();
        check("off_idle", 32'(pwr_state), 32'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        check("drop_off", 32'(start_drop), 32'd1);
        check("drop_off_result", 32'(result), 32'h0001);

        power_up();
        check("on_iso", 32'(iso_active), 32'd0);

        issue(4'd0, 16'hFFFF, 16'h0002, 1'b0);
        check("add_done", 32'(done), 32'd1);
        check("add_result", 32'(result), 32'h0001);
        check("add_busy", 32'(busy), 32'd0);
        issue(4'd1, 16'h0000, 16'h0001, 1'b0);
        check("sub_result", 32'(result), 32'hFFFF);

        for (int i = 0; i < 10; i++) issue(t_op[i], t_a[i], t_b[i], 1'b0);
        for (int i = 0; i < 12; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op == 4'd7) op = 4'd8;
            issue(op, W'($urandom), W'($urandom_range(0, 31)), 1'b0);
        end
        tick();
        check("ops_drained", 32'(exp_q.size()), 32'd0);

        // MUL with a start arriving while busy
        issue(4'd7, 16'h0100, 16'h0101, 1'b0);
        check("mul_busy1", 32'(busy), 32'd1);
        check("mul_nodone1", 32'(done), 32'd0);
        A = 16'h0003; B = 16'h0004; opcode = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("mul_busy2", 32'(busy), 32'd1);
        check("drop_busy", 32'(start_drop), 32'd1);
        tick();
        check("mul_busy3", 32'(busy), 32'd1);
        check("drop_once", 32'(start_drop), 32'd0);
        tick();
        check("mul_busy_end", 32'(busy), 32'd0);
        check("mul_done", 32'(done), 32'd1);
        check("mul_result", 32'(result), 32'h0100);
        repeat (2) tick();

        // MUL in flight, then power-down request -> DRAIN -> ISO -> OFF
        issue(4'd7, 16'h0003, 16'h0005, 1'b0);
        pwr_down_req = 1'b1;
        tick();
        pwr_down_req = 1'b0;
        check("drain_state", 32'(pwr_state), 32'd3);
        check("drain_iso", 32'(iso_active), 32'd0);
        start = 1'b1; opcode = 4'd0;
        tick();
        start = 1'b0;
        check("drop_drain", 32'(start_drop), 32'd1);
        tick();
        check("drain_done", 32'(done), 32'd1);
        check("drain_hold", 32'(pwr_state), 32'd3);
        tick();
        check("iso_state", 32'(pwr_state), 32'd4);
        check("iso_result", 32'(result), 32'h0001);
        check("iso_pwr_en", 32'(pwr_en), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("iso_state2", 32'(pwr_state), 32'd4);
        check("drop_iso", 32'(start_drop), 32'd1);
        check("iso_result2", 32'(result), 32'h0001);
        tick();
        check("off_state", 32'(pwr_state), 32'd0);
        check("off_pwr_en", 32'(pwr_en), 32'd0);

        // Re-power: start and pwr_down_req in PWR_UP are ignored
        pwr_up_req = 1'b1;
        tick();
        pwr_up_req = 1'b0;
        start = 1'b1; pwr_down_req = 1'b1;
        tick();
        start = 1'b0; pwr_down_req = 1'b0;
        check("drop_pwrup", 32'(start_drop), 32'd1);
        check("pwrup_ignore_down", 32'(pwr_state), 32'd1);
        repeat (2) tick();
        check("pwrup_hold", 32'(pwr_state), 32'd1);
        tick();
        check("repower_on", 32'(pwr_state), 32'd2);
        check("repower_result", 32'(result), 32'h0000);

        // Start and power-down together on an idle ON
        issue(4'd0, 16'h0005, 16'h0006, 1'b1);
        check("sd_drain", 32'(pwr_state), 32'd3);
        check("sd_done", 32'(done), 32'd1);
        tick();
        check("sd_iso", 32'(pwr_state), 32'd4);
        repeat (2) tick();
        check("sd_off", 32'(pwr_state), 32'd0);

        // Both requests in OFF: up wins; then reset during PWR_UP
        pwr_up_req = 1'b1; pwr_down_req = 1'b1;
        tick();
        pwr_up_req = 1'b0; pwr_down_req = 1'b0;
        check("both_req_up", 32'(pwr_state), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check("rst_pwrup_state", 32'(pwr_state), 32'd0);
        check("rst_pwrup_en", 32'(pwr_en), 32'd0);
        tick();
        rst = 1'b0;

        // Reset mid-MUL aborts with no done
        power_up();
        issue(4'd7, 16'h0011, 16'h0022, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("rst_mul_busy", 32'(busy), 32'd0);
        check("rst_mul_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("rst_mul_state", 32'(pwr_state), 32'd0);
        check("rst_mul_nodone", 32'(done), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
